// File: rtl/instr_fetch_responder_if.sv
// Fetch-side bundle for instr_fetch_responder: request, flush, memory read port and response.
// slave is the responder's view; master is the pipeline/memory environment's view.
interface instr_fetch_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic                  flush;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_instr;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_addr, flush, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport master (
    output req_valid, req_addr, flush, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: issues one-cycle-latency memory reads and queues {instr, addr, err}
// in a small in-order FIFO. Optional misaligned-PC trap enabled by `define FETCH_MISALIGN_CHK_EN.
module instr_fetch_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_fetch_responder_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;

  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];

  logic [CW:0]           occupancy;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  misalign;
  logic [DATA_WIDTH-1:0] push_instr;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
  logic inflight_err_q, inflight_err_d;
  logic err_q [DEPTH];

  assign misalign   = (bus.req_addr[1:0] != 2'b00);
  assign push_instr = inflight_err_q ? NOP_INSTR : bus.mem_rdata;
  assign bus.rsp_err = err_q[rd_ptr_q];
`else
  assign misalign    = 1'b0;
  assign push_instr  = bus.mem_rdata;
  assign bus.rsp_err = 1'b0;
`endif

  // The outstanding read counts against capacity so its data always has a slot to land in.
  assign occupancy     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign bus.req_ready = rst && !bus.flush && (occupancy < DEPTH_W);
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.mem_rd_en = accept && !misalign;
  assign bus.mem_addr  = bus.req_addr;

  assign bus.rsp_valid = rst && (count_q != '0) && !bus.flush;
  assign bus.rsp_instr = instr_q[rd_ptr_q];
  assign bus.rsp_addr  = addr_q[rd_ptr_q];

  assign pop  = bus.rsp_valid && bus.rsp_ready;
  assign push = inflight_q && !bus.flush;

  always_comb begin
    count_d         = count_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = accept;
    inflight_addr_d = accept ? bus.req_addr : inflight_addr_q;
    if (bus.flush) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  // Storage is reset so the head outputs read as zero while in reset and before the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        addr_q[i]  <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= push_instr;
      addr_q[wr_ptr_q]  <= inflight_addr_q;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  assign inflight_err_d = accept ? misalign : inflight_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) err_q[i] <= 1'b0;
    end else begin
      inflight_err_q <= inflight_err_d;
      if (push) err_q[wr_ptr_q] <= inflight_err_q;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench for instr_fetch_responder: directed scenarios then random traffic, all
// checked each cycle against a transaction-level queue model of the fetch pipeline.
module tb_instr_fetch_responder;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  bit          pend_valid;
  logic [31:0] pend_addr;
  bit          pend_err;
  bit          last_acc;
  logic        prev_rd;
  logic [31:0] prev_addr;
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;

  // Instruction memory contents as seen by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  function automatic bit misaligned(input logic [31:0] a);
    return (a[1:0] != 2'b00) && MISALIGN_EN;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle against the model, advance the model, then drive memory data.
  task automatic cycle();
    bit   exp_ready, exp_valid, exp_rd, pop;
    rsp_t head;
    @(negedge clk);
    exp_ready = rst && !bus.flush && ((exp_q.size() + int'(pend_valid)) < DEPTH);
    exp_valid = rst && (exp_q.size() != 0) && !bus.flush;
    last_acc  = bus.req_valid && exp_ready;
    exp_rd    = last_acc && !misaligned(bus.req_addr);
    head      = '0;
    if (exp_valid) head = exp_q[0];

    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
    check("mem_rd_en", 64'(bus.mem_rd_en), 64'(exp_rd));
    if (exp_rd) check("mem_addr", 64'(bus.mem_addr), 64'(bus.req_addr));
    if (!rst || exp_valid) begin
      check("rsp_instr", 64'(bus.rsp_instr), 64'(head.instr));
      check("rsp_addr",  64'(bus.rsp_addr),  64'(head.addr));
      check("rsp_err",   64'(bus.rsp_err),   64'(head.err));
    end else if (!MISALIGN_EN) begin
      check("rsp_err_const", 64'(bus.rsp_err), 64'(0));
    end

    prev_rd   = bus.mem_rd_en;
    prev_addr = bus.mem_addr;
    pop       = exp_valid && bus.rsp_ready;
    if (pop)
      $display("rsp  addr=%08h instr=%08h err=%0d", bus.rsp_addr, bus.rsp_instr, bus.rsp_err);

    if (!rst || bus.flush) begin
      exp_q.delete();
      pend_valid = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (pend_valid)
        exp_q.push_back({pend_addr, (pend_err ? NOP : mem_word(pend_addr)), pend_err});
      pend_valid = last_acc;
      pend_addr  = bus.req_addr;
      pend_err   = misaligned(bus.req_addr);
    end

    @(posedge clk);
    #1;
    bus.mem_rdata = prev_rd ? mem_word(prev_addr) : $urandom();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present one request and hold it until accepted, within a cycle budget.
  task automatic issue(input logic [31:0] a);
    bit got;
    got = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = last_acc;
    end
    bus.req_valid = 1'b0;
    check("issue_accepted", 64'(got), 64'(1));
  endtask

  initial begin
    int cnt;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.mem_rdata = '0;
    pend_valid    = 1'b0;
    pend_addr     = '0;
    pend_err      = 1'b0;
    last_acc      = 1'b0;
    prev_rd       = 1'b0;
    prev_addr     = '0;

    // Reset state, then first fetch with 2-cycle response latency.
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(1);
    bus.rsp_ready = 1'b1;
    issue(32'hBFC0_0000);
    idle(3);

    // Stalled consumer: only two of three back-to-back requests accepted, then in-order drain.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hBFC0_0000;
    cnt = 0;
    for (int i = 0; i < 14 && cnt < 3; i++) begin
      if (i == 6) bus.rsp_ready = 1'b1;
      cycle();
      if (last_acc) begin
        cnt++;
        bus.req_addr = 32'hBFC0_0000 + 32'(4 * cnt);
      end
    end
    bus.req_valid = 1'b0;
    check("backpressure_accepts", 64'(cnt), 64'(3));
    idle(4);

    // Flush with one queued entry and one read in flight.
    bus.rsp_ready = 1'b0;
    issue(32'hBFC0_000C);
    idle(2);
    issue(32'hBFC0_0010);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hBFC0_0014;
    bus.flush     = 1'b1;
    cycle();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    issue(32'hBFC0_0100);
    idle(4);

    // Full FIFO, consumer handshake and new request presented together.
    bus.rsp_ready = 1'b0;
    issue(32'hBFC0_00A0);
    issue(32'hBFC0_00A4);
    idle(2);
    bus.rsp_ready = 1'b1;
    issue(32'hBFC0_00A8);
    idle(5);

    // Misaligned PC.
    issue(32'hBFC0_0002);
    idle(3);

    // Reset one cycle after accept drops the in-flight read.
    issue(32'hBFC0_0200);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(4);
    issue(32'hBFC0_0204);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_addr  = 32'hBFC0_0000 + (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 7) == 0) bus.req_addr[1:0] = 2'($urandom_range(1, 3));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    idle(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_responder.md
INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the fetch address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the instruction word width.
REQ-003 SHALL have parameter DEPTH, default 2, the response FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  1  a fetch request is present.
REQ-007 SHALL have port req_addr  input  ADDR_WIDTH  the fetch address (PC value).
REQ-008 SHALL have port req_ready  output  1  the block accepts the request this cycle.
REQ-009 SHALL have port flush  input  1  a redirect (taken branch/jump); drop all pending fetches.
REQ-010 SHALL have port mem_rd_en  output  1  a read strobe to instruction memory.
REQ-011 SHALL have port mem_addr  output  ADDR_WIDTH  the memory read address.
REQ-012 SHALL have port mem_rdata  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 SHALL have port rsp_valid  output  1  a response word is available.
REQ-014 SHALL have port rsp_ready  input  1  the consumer takes the response.
REQ-015 SHALL have port rsp_instr  output  DATA_WIDTH  the instruction word.
REQ-016 SHALL have port rsp_addr  output  ADDR_WIDTH  the address the word was fetched from.
REQ-017 SHALL have port rsp_err  output  1  the fetch error flag (see Configuration).

Function
REQ-018 SHALL accept a request when req_valid && req_ready, and SHALL drive mem_rd_en=1 and mem_addr=req_addr combinationally in the same cycle.
REQ-019 SHALL assert req_ready = !flush && (fifo_count + inflight) < DEPTH, where inflight is a 1-bit register set on accept.
REQ-020 SHALL capture {mem_rdata, the registered address, err} into the FIFO on the edge ending the cycle after accept, so rsp_valid rises 2 cycles after accept when the FIFO was empty.
REQ-021 SHALL drive rsp_valid = (fifo_count != 0) && !flush, with rsp_instr/rsp_addr/rsp_err taken from the FIFO head.
REQ-022 SHALL pop the head when rsp_valid && rsp_ready, and SHALL return responses in request order.
REQ-023 SHALL keep rsp_instr/rsp_addr/rsp_err stable while rsp_valid && !rsp_ready.
REQ-024 SHALL handle a push and pop in the same cycle with fifo_count unchanged, including when full.
REQ-025 SHALL, on flush=1, clear fifo_count, read/write pointers and inflight at the next edge, discard the mem_rdata returning in the following cycle, and accept no request that cycle.
REQ-026 SHALL let flush take priority over a simultaneous rsp handshake; the dropped head does not count as consumed.
REQ-027 SHALL wrap the FIFO pointers modulo DEPTH; counter width SHALL be $clog2(DEPTH)+1.
REQ-028 SHALL sustain one accept per cycle when rsp_ready is held 1.

Reset
REQ-029 SHALL, while rst=0, force fifo_count=0, pointers=0, inflight=0, rsp_valid=0, req_ready=0, mem_rd_en=0, rsp_instr=0, rsp_addr=0, rsp_err=0.
REQ-030 SHALL discard any in-flight read when reset is asserted mid-operation; the first response after reset release SHALL come from a post-reset request.

Configuration
REQ-031 SHALL, with FETCH_MISALIGN_CHK_EN defined, flag a request with req_addr[1:0]!=0: no mem_rd_en, a response still queued with rsp_err=1 and rsp_instr=32'h00000013 (NOP).
REQ-032 SHALL, without FETCH_MISALIGN_CHK_EN, issue every address to memory unchanged, and SHALL hold rsp_err constant 0.

Verification
REQ-033 SHALL cover: reset release, req 0xBFC00000 with mem returning 0x00500093 -> rsp_valid 2 cycles after accept, rsp_addr=0xBFC00000, rsp_instr=0x00500093.
REQ-034 SHALL cover: rsp_ready=0, with 3 back-to-back requests 0xBFC00000/04/08 -> req_ready low after 2 accepts; after rsp_ready=1, responses arrive in order.
REQ-035 SHALL cover: flush in the cycle after accepting 0xBFC00010 with 1 FIFO entry pending -> rsp_valid=0 next cycle, and the next request 0xBFC00100 is the first response.
REQ-036 SHALL cover: full FIFO with rsp handshake and a new request in the same cycle -> count stays 2 and no data is lost.
REQ-037 SHALL cover, with FETCH_MISALIGN_CHK_EN: req 0xBFC00002 -> mem_rd_en=0, rsp_err=1, rsp_instr=0x00000013; without the macro, mem_addr=0xBFC00002 and rsp_err=0.
REQ-038 SHALL cover: rst=0 one cycle after accept -> no response after release until a new request.
